// File: rtl/crc16_frame_engine.sv
// crc16_frame_engine: streaming CRC-16 generate/check engine, 1..DATA_BYTES bytes per beat.
// Optional saturating check-failure counter (err_cnt) enabled by defining CRC16_FRAME_ERRCNT_EN.
module crc16_frame_engine #(
    parameter logic [15:0] POLY       = 16'h8005,
    parameter logic [15:0] INIT       = 16'hFFFF,
    parameter bit          REFIN      = 1'b1,
    parameter bit          REFOUT     = 1'b1,
    parameter logic [15:0] XOROUT     = 16'h0000,
    parameter logic [15:0] RESIDUE    = 16'h0000,
    parameter int          DATA_BYTES = 1
) (
    input  logic                    sclk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic [15:0]             crc_value,
    output logic                    done,
    output logic                    crc_ok,
    output logic                    busy
`ifdef CRC16_FRAME_ERRCNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, ACC, EMIT_LO, EMIT_HI, FIN} state_t;

    state_t      r_state, w_state_nx;
    logic [15:0] r_crc, w_crc_nx, w_refl;
    logic        r_mode, r_ok, w_run;

    function automatic logic [15:0] f_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] v;
        v = c;
        for (int i = 0; i < 8; i++) v[15-i] = c[15-i] ^ (REFIN ? b[i] : b[7-i]);
        for (int i = 0; i < 8; i++) v = v[15] ? ({v[14:0], 1'b0} ^ POLY) : {v[14:0], 1'b0};
        return v;
    endfunction

    // Lanes absorb in order; the first cleared keep bit masks every lane above it.
    always_comb begin
        w_crc_nx = r_crc;
        w_run    = 1'b1;
        for (int i = 0; i < DATA_BYTES; i++) begin
            w_run = w_run & in_keep[i];
            if (w_run) w_crc_nx = f_byte(w_crc_nx, in_data[8*i +: 8]);
        end
    end

    assign w_refl    = {<<{r_crc}};
    assign crc_value = (REFOUT ? w_refl : r_crc) ^ XOROUT;
    assign crc_ok    = r_ok;

    always_comb begin
        w_state_nx = r_state;
        in_ready   = r_state == ACC;
        busy       = r_state != IDLE;
        out_valid  = (r_state == EMIT_LO) || (r_state == EMIT_HI);
        out_last   = r_state == EMIT_HI;
        out_data   = (r_state == EMIT_LO) ? crc_value[7:0] : (r_state == EMIT_HI) ? crc_value[15:8] : 8'h00;
        done       = (r_state == FIN) && !start;
        case (r_state)
            ACC:     if (in_valid && in_last) w_state_nx = r_mode ? FIN : EMIT_LO;
            EMIT_LO: if (out_ready) w_state_nx = EMIT_HI;
            EMIT_HI: if (out_ready) w_state_nx = FIN;
            FIN:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (start) w_state_nx = ACC;
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc  <= INIT;
            r_mode <= 1'b0;
            r_ok   <= 1'b0;
        end else if (start) begin
            r_crc  <= INIT;
            r_mode <= mode;
            r_ok   <= 1'b0;
        end else begin
            if (r_state == ACC && in_valid) r_crc <= w_crc_nx;
            if (r_state == FIN && r_mode) r_ok <= r_crc == RESIDUE;
        end
    end

`ifdef CRC16_FRAME_ERRCNT_EN
    logic [7:0] r_err;
    assign err_cnt = r_err;
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) r_err <= 8'h00;
        else if (done && r_mode && r_crc != RESIDUE && r_err != 8'hFF) r_err <= r_err + 8'h01;
    end
`endif
endmodule

// File: tb/tb_crc16_frame_engine.sv
// tb_crc16_frame_engine: table-driven frames plus hand-written corner sequences,
// with a byte scoreboard on the CRC output stream (DATA_BYTES=4 instance).
module tb_crc16_frame_engine;
    logic        sclk = 1'b0, reset_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_keep = '0;
    logic        in_ready, out_valid, out_last, done, crc_ok, busy;
    logic [7:0]  out_data;
    logic [15:0] crc_value;
`ifdef CRC16_FRAME_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_chk = 0, n_pass = 0, n_done = 0;
    logic [8:0] sb[$];

    typedef struct {
        bit          md;
        int          n;
        int          lanes;
        logic [95:0] d;
        logic [15:0] crc;
        bit          ok;
    } vec_t;
    vec_t tv[6];

    crc16_frame_engine #(.DATA_BYTES(4)) dut (
        .sclk(sclk), .reset_n(reset_n), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .crc_value(crc_value), .done(done), .crc_ok(crc_ok), .busy(busy)
`ifdef CRC16_FRAME_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge sclk) begin
        if (done) n_done++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_underflow: got byte %0h expected none", out_data);
            end else chk("out_byte", {out_last, out_data}, sb.pop_front());
        end
    end

    // Bit-serial reflected CRC-16/MODBUS reference.
    function automatic logic [15:0] model(input logic [95:0] d, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {8'h00, d[8*i +: 8]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [95:0] mk(input string s);
        logic [95:0] d = '0;
        for (int i = 0; i < s.len(); i++) d[8*i +: 8] = s[i];
        return d;
    endfunction

    task automatic push_exp(input logic [15:0] c);
        sb.push_back({1'b0, c[7:0]});
        sb.push_back({1'b1, c[15:8]});
    endtask

    task automatic start_frame(input bit m);
        start = 1'b1;
        mode  = m;
        @(posedge sclk); #1;
        start = 1'b0;
        chk("start_in_ready", in_ready, 1);
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input bit l);
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        chk("beat_in_ready", in_ready, 1);
        @(posedge sclk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_keep = '0;
    endtask

    task automatic send(input logic [95:0] d, input int n, input int lanes);
        int i = 0;
        logic [31:0] bd;
        logic [3:0]  bk;
        do begin
            bd = '0; bk = '0;
            for (int l = 0; l < lanes && i < n; l++) begin
                bd[8*l +: 8] = d[8*i +: 8];
                bk[l] = 1'b1;
                i++;
            end
            beat(bd, bk, i >= n);
        end while (i < n);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge sclk); #1;
            cyc++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, d0;
        start_frame(v.md);
        if (!v.md) push_exp(v.crc);
        out_ready = 1'b1;
        d0 = n_done;
        send(v.d, v.n, v.lanes);
        chk("exit_latency", v.md ? done : out_valid, 1);
        wait_done(cyc);
        chk("done_cycles", cyc, v.md ? 0 : 2);
        chk("crc_value", crc_value, v.crc);
        @(posedge sclk); #1;
        chk("done_pulse", done, 0);
        chk("crc_ok", crc_ok, v.ok);
        chk("busy_idle", busy, 0);
        chk("done_count", n_done - d0, 1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_out_last"}, out_last, 0);
        chk({nm, "_crc_value"}, crc_value, 16'hFFFF);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_crc_ok"}, crc_ok, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [95:0] d, d2;
        int cyc, d0;
        d = mk("123456789");
        d[72 +: 8] = 8'h37;
        d[80 +: 8] = 8'h4B;
        d2 = d;
        d2[16 +: 8] ^= 8'h01;
        tv[0] = '{1'b0, 9, 1, mk("123456789"), 16'h4B37, 1'b0};
        tv[1] = '{1'b0, 9, 4, mk("123456789"), 16'h4B37, 1'b0};
        tv[2] = '{1'b1, 11, 1, d, 16'h0000, 1'b1};
        tv[3] = '{1'b1, 11, 3, d2, model(d2, 11), 1'b0};
        tv[4] = '{1'b0, 5, 2, mk("Hello"), model(mk("Hello"), 5), 1'b0};
        tv[5] = '{1'b0, 0, 4, '0, 16'hFFFF, 1'b0};

        #12;
        chk_reset_vals("rst");
`ifdef CRC16_FRAME_ERRCNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        @(posedge sclk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(tv[i]);
`ifdef CRC16_FRAME_ERRCNT_EN
        chk("err_cnt_first", err_cnt, 1);
`endif

        // Non-contiguous keep and an empty non-last beat.
        start_frame(1'b0);
        push_exp(model(mk("123"), 3));
        out_ready = 1'b1;
        beat(32'h3938_5A31, 4'b1101, 1'b0);
        beat(32'h4142_4344, 4'b0000, 1'b0);
        beat(32'h0000_3332, 4'b0011, 1'b1);
        wait_done(cyc);
        chk("noncontig_crc", crc_value, model(mk("123"), 3));
        @(posedge sclk); #1;

        // Output backpressure in EMIT_LO.
        start_frame(1'b0);
        push_exp(16'h4B37);
        out_ready = 1'b0;
        d0 = n_done;
        send(mk("123456789"), 9, 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 8'h37);
            chk("bp_no_done", done, 0);
            @(posedge sclk); #1;
        end
        out_ready = 1'b1;
        wait_done(cyc);
        chk("bp_done_cycles", cyc, 2);
        chk("bp_crc", crc_value, 16'h4B37);
        @(posedge sclk); #1;
        chk("bp_done_count", n_done - d0, 1);

        // Abort mid-frame; the beat coinciding with start is dropped.
        start_frame(1'b0);
        d0 = n_done;
        beat(32'h3433_3231, 4'b1111, 1'b0);
        start = 1'b1; mode = 1'b0;
        in_valid = 1'b1; in_data = 32'h5A; in_keep = 4'b0001; in_last = 1'b1;
        @(posedge sclk); #1;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_keep = '0;
        chk("abort_in_ready", in_ready, 1);
        push_exp(16'h4B37);
        out_ready = 1'b1;
        send(mk("123456789"), 9, 3);
        wait_done(cyc);
        chk("abort_crc", crc_value, 16'h4B37);
        @(posedge sclk); #1;
        chk("abort_done_count", n_done - d0, 1);

        // Reset asserted in EMIT_HI.
        start_frame(1'b0);
        sb.push_back({1'b0, 8'h37});
        out_ready = 1'b0;
        send(mk("123456789"), 9, 1);
        out_ready = 1'b1;
        @(posedge sclk); #1;
        out_ready = 1'b0;
        chk("emit_hi_last", out_last, 1);
        chk("emit_hi_data", out_data, 8'h4B);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
`ifdef CRC16_FRAME_ERRCNT_EN
        chk("midrst_err_cnt", err_cnt, 0);
`endif
        @(posedge sclk); #1;
        reset_n = 1'b1;
        run_vec(tv[0]);

`ifdef CRC16_FRAME_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            start_frame(1'b1);
            beat(32'h3433_3231, 4'b1111, 1'b1);
            @(posedge sclk); #1;
        end
        chk("err_cnt_sat", err_cnt, 8'hFF);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/crc16_frame_engine.md
# crc16_frame_engine

Parametrised, streaming CRC-16 engine for the bq79606 UART frame path. It accepts 1–4 bytes per beat over a valid/ready handshake and runs in one of two modes. In generate mode it emits the two CRC bytes, LSB first, as a handshaked byte stream appended after the frame. In check mode it absorbs frame plus received CRC and flags pass/fail. It sits between the frame builder/parser and the UART TX/RX byte FIFOs, replacing the fixed 8-bit CRC16 calculator.

## Interface
- POLY, 16'h8005, generator polynomial, normal form
- INIT, 16'hFFFF, register value loaded on start
- REFIN, 1, reflect each input byte before absorption
- REFOUT, 1, reflect final register before XOROUT
- XOROUT, 16'h0000, final XOR
- RESIDUE, 16'h0000, raw register value meaning "pass" in check mode
- DATA_BYTES, 1, bytes per input beat (1..4)

Ports:
- sclk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: load INIT, enter ACC; accepted in any state
- mode  in  1  sampled on start: 0 = generate, 1 = check
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat
- in_data  in  8*DATA_BYTES  beat data; lane 0 = bits[7:0] = first byte
- in_keep  in  DATA_BYTES  lane enables, contiguous from lane 0
- in_last  in  1  final beat of frame
- out_valid  out  1  CRC byte valid (generate mode)
- out_ready  in  1  downstream accepts CRC byte
- out_data  out  8  CRC byte
- out_last  out  1  marks second (high) CRC byte
- crc_value  out  16  final CRC (after REFOUT/XOROUT), held until next start
- done  out  1  one-cycle pulse at frame completion
- crc_ok  out  1  check-mode result, held until next start
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACC, EMIT_LO, EMIT_HI, FIN.
- IDLE: in_ready=0; start → ACC, crc_reg←INIT, mode latched, crc_ok←0.
- ACC: in_ready=1. On in_valid&in_ready, enabled lanes are absorbed in lane order (0 first), one byte per lane, within a single cycle. Implement as unrolled byte updates.
- ACC exit on in_last: generate → EMIT_LO; check → FIN.
- in_keep=0 on a non-last beat: beat is consumed with no effect. in_keep=0 with in_last: frame ends. An empty frame gives CRC = INIT^XOROUT.
- Non-contiguous in_keep: only the lanes below the first zero are absorbed.
- EMIT_LO: out_valid=1, out_data=crc_value[7:0]. Advance on out_ready.
- EMIT_HI: out_data=crc_value[15:8], out_last=1. On out_ready → FIN.
- FIN: done=1 for one cycle. In check mode, crc_ok←(crc_reg==RESIDUE). Then → IDLE.
- start in any non-IDLE state aborts the current frame: reload INIT, → ACC, no done pulse. start beats a simultaneous in_valid handshake, and that beat is dropped.
- crc_value is combinational from crc_reg through REFOUT and XOROUT. It is stable from ACC exit until the next start.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, crc_value=INIT^XOROUT after transform, done=0, crc_ok=0, busy=0, state IDLE, crc_reg=INIT.
- start accepted at edge N → in_ready=1 from N+1.
- Last beat accepted at edge N:
  - generate: out_valid=1 at N+1
  - check: done at N+1
- Generate: done one cycle after the EMIT_HI handshake.
- out_valid is held with stable out_data while out_ready=0.
- Throughput: one beat per cycle in ACC. No bubbles between beats.
- reset_n asserted mid-frame: everything returns to reset values immediately, with no done pulse.

## Configuration
- CRC16_FRAME_ERRCNT_EN defined:
  - adds port err_cnt  out  8.
  - It is a saturating count of check-mode FIN cycles with crc_ok=0. It holds at 255 and is cleared only by reset_n.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Defaults (CRC-16/MODBUS, DATA_BYTES=1), generate, bytes "123456789" → crc_value=16'h4B37; out_data 8'h37 then 8'h4B with out_last; done 1 cycle after.
- DATA_BYTES=4, same 9 bytes in 3 beats, last in_keep=4'b0001 → crc_value=16'h4B37; in_ready stays high for all three consecutive beats.
- Check mode, "123456789",8'h37,8'h4B → crc_ok=1. Flip one bit of byte 3 → crc_ok=0 and err_cnt 0→1 (with CRC16_FRAME_ERRCNT_EN).
- Generate with out_ready low for 5 cycles in EMIT_LO → out_valid=1 and out_data=8'h37 stable throughout; no done until both bytes are accepted.
- Empty frame (in_last with in_keep=0) → crc_value=16'hFFFF, out bytes FF, FF. Separately, start mid-frame after 4 bytes, then send "123456789" → 16'h4B37, with no done from the aborted frame.
- reset_n low during EMIT_HI → all outputs reset values; next start+frame gives the correct CRC. 300 failing check frames → err_cnt=255.
